// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Size encodings, FSM states and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LD,
    ST,
    RMW_RD,
    RMW_WR,
    RESP
  } lsu_state_e;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    return (size == SZ_RSVD)
        || (size == SZ_HALF && lo[0])
        || (size == SZ_WORD && lo != 2'b00);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle and
// word-only data-memory port bundle.
interface lsu_req_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

interface lsu_mem_if #(
  parameter int ADDR_W = 32
);
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] read_address;
  logic [ADDR_W-1:0] write_address;
  logic [31:0]       Write_data;
  logic [31:0]       MemData_in;

  modport master (
    output MemRead, MemWrite,
    output read_address, write_address,
    output Write_data,
    input  MemData_in
  );

  modport slave (
    input  MemRead, MemWrite,
    input  read_address, write_address,
    input  Write_data,
    output MemData_in
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// Little-endian lane extract with sign/zero
// extension, and lane merge for sub-word stores.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = i_word[{i_lane, 3'b000} +: 8];
    w_half  = i_lane[1] ? i_word[31:16]
                        : i_word[15:0];
    o_load  = i_word;
    o_merge = i_word;
    unique case (1'b1)
      i_size == SZ_BYTE: begin
        o_load = {{24{w_byte[7] & ~i_unsigned}},
                  w_byte};
        o_merge[{i_lane, 3'b000} +: 8] =
          i_wdata[7:0];
      end
      i_size == SZ_HALF: begin
        o_load = {{16{w_half[15] & ~i_unsigned}},
                  w_half};
        if (i_lane[1]) o_merge[31:16] = i_wdata;
        else           o_merge[15:0]  = i_wdata;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: word-indexed loads/stores,
// read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORD_INDEX_W = 16,
  parameter int ADDR_W       = 32
) (
  input logic       clk,
  input logic       reset,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);
  lsu_state_e              r_state;
  logic                    r_we;
  logic                    r_uns;
  logic                    r_err;
  logic [1:0]              r_size;
  logic [WORD_INDEX_W+1:0] r_addr;
  logic [31:0]             r_wdata;
  logic [31:0]             r_merge;
  logic [31:0]             r_rdata;

  logic [31:0]       w_lane_word;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;
  logic [ADDR_W-1:0] w_widx;
  logic              w_bad;

  assign w_bad = misaligned(req.req_size,
                            req.req_addr[1:0]);
  assign w_widx =
    ADDR_W'(r_addr[WORD_INDEX_W+1:2]);

  // One lane unit serves both the load and the merge
  assign w_lane_word = (r_state == LD)
                     ? mem.MemData_in : r_merge;

  lsu_byte_lane u_lane (
    .i_word     (w_lane_word),
    .i_lane     (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata[15:0]),
    .o_load     (w_load),
    .o_merge    (w_merged)
  );

  assign req.req_ready = (r_state == IDLE)
                      && !reset;
  assign req.rsp_valid = (r_state == RESP);
  assign req.rsp_rdata = r_rdata;
  assign req.rsp_err   = r_err;

  assign mem.MemRead  = (r_state == LD)
                     || (r_state == RMW_RD);
  assign mem.MemWrite = (r_state == ST)
                     || (r_state == RMW_WR);
  assign mem.read_address  = w_widx;
  assign mem.write_address = w_widx;

  always_comb begin
    mem.Write_data = '0;
    if (r_state == ST)
      mem.Write_data = r_wdata;
    else if (r_state == RMW_WR)
      mem.Write_data = w_merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= SZ_BYTE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_merge <= '0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (req.req_valid) begin
          r_we    <= req.req_we;
          r_uns   <= req.req_unsigned;
          r_size  <= req.req_size;
          r_addr  <= req.req_addr[WORD_INDEX_W+1:0];
          r_wdata <= req.req_wdata;
          r_rdata <= '0;
          r_err   <= w_bad;
          if (w_bad)
            r_state <= RESP;
          else if (!req.req_we)
            r_state <= LD;
          else if (req.req_size == SZ_WORD)
            r_state <= ST;
          else
            r_state <= RMW_RD;
        end
        LD: begin
          r_rdata <= w_load;
          r_state <= RESP;
        end
        ST: r_state <= RESP;
        RMW_RD: begin
          r_merge <= mem.MemData_in;
          r_state <= RMW_WR;
        end
        RMW_WR: r_state <= RESP;
        RESP: if (req.rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed plan plus
// random traffic against a word-array model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tot = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [31:0] last_wd = '0;
  logic [31:0] exp_idx = '0;
  logic [31:0] mem_arr [0:65535];
  logic [31:0] ref_mem [0:65535];

  lsu_req_if rq ();
  lsu_mem_if mi ();

  load_store_unit dut (
    .clk   (clk),
    .reset (reset),
    .req   (rq),
    .mem   (mi)
  );

  always #5 clk = ~clk;

  assign mi.MemData_in =
    mem_arr[mi.read_address[15:0]];

  always @(posedge clk)
    if (mi.MemWrite)
      mem_arr[mi.write_address[15:0]] <=
        mi.Write_data;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mi.MemRead && mi.MemWrite)
      chk("overlap", 1, 0);
    if (mi.MemRead) begin
      rd_cnt++;
      chk("raddr", mi.read_address, exp_idx);
    end
    if (mi.MemWrite) begin
      wr_cnt++;
      last_wd = mi.Write_data;
      chk("waddr", mi.write_address, exp_idx);
    end
  end

  function automatic logic [31:0] ref_load(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic        uns,
    input logic [1:0]  lo
  );
    logic [31:0] v;
    if (sz == 2'd2) return w;
    if (sz == 2'd0) begin
      v = (w >> (8 * lo)) & 32'hFF;
      if (!uns && v >= 32'h80)
        v = v | 32'hFFFF_FF00;
    end else begin
      v = (w >> (16 * lo[1])) & 32'hFFFF;
      if (!uns && v >= 32'h8000)
        v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic do_req(input logic        we,
                        input logic [1:0]  sz,
                        input logic        uns,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input int          hold);
    logic err;
    logic [31:0] idx, old, exp_rd, exp_wd;
    int lat, exp_lat, exp_r, exp_w, sh, t;
    err = (sz == 2'd3)
       || (sz == 2'd1 && addr[0])
       || (sz == 2'd2 && addr[1:0] != 2'd0);
    idx = {16'h0, addr[17:2]};
    old = ref_mem[idx[15:0]];
    sh  = 8 * int'(addr[1:0]);
    exp_rd = '0; exp_wd = '0;
    exp_r = 0; exp_w = 0; exp_lat = 1;
    if (!err && !we) begin
      exp_rd = ref_load(old, sz, uns, addr[1:0]);
      exp_r = 1; exp_lat = 2;
    end else if (!err && sz == 2'd2) begin
      exp_wd = wd; exp_w = 1; exp_lat = 2;
    end else if (!err) begin
      if (sz == 2'd0)
        exp_wd = (old & ~(32'hFF << sh))
               | ((wd & 32'hFF) << sh);
      else
        exp_wd = (old & ~(32'hFFFF << sh))
               | ((wd & 32'hFFFF) << sh);
      exp_r = 1; exp_w = 1; exp_lat = 3;
    end
    if (exp_w != 0) ref_mem[idx[15:0]] = exp_wd;
    exp_idx = idx;

    @(negedge clk);
    t = 0;
    while (!rq.req_ready && t < 20) begin
      @(negedge clk); t++;
    end
    chk("ready", rq.req_ready, 1);
    rq.req_valid    = 1'b1;
    rq.req_we       = we;
    rq.req_size     = sz;
    rq.req_unsigned = uns;
    rq.req_addr     = addr;
    rq.req_wdata    = wd;
    @(posedge clk); #1;
    rd_cnt = 0; wr_cnt = 0;
    rq.req_valid = 1'b0;

    @(negedge clk);
    lat = 1;
    while (!rq.rsp_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    chk("lat", lat, exp_lat);
    chk("valid", rq.rsp_valid, 1);
    chk("rdata", rq.rsp_rdata, exp_rd);
    chk("err", rq.rsp_err, err);

    for (int i = 0; i < hold; i++) begin
      rq.req_valid = 1'b1;
      @(negedge clk);
      chk("hold_v", rq.rsp_valid, 1);
      chk("hold_d", rq.rsp_rdata, exp_rd);
      chk("hold_e", rq.rsp_err, err);
      chk("hold_rdy", rq.req_ready, 0);
    end
    chk("rd_cnt", rd_cnt, exp_r);
    chk("wr_cnt", wr_cnt, exp_w);
    if (exp_w != 0) chk("wdata", last_wd, exp_wd);

    rq.rsp_ready = 1'b1;
    @(posedge clk); #1;
    rq.rsp_ready = 1'b0;
    rq.req_valid = 1'b0;
    chk("mem", mem_arr[idx[15:0]],
        ref_mem[idx[15:0]]);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem_arr[i] = '0;
      ref_mem[i] = '0;
    end
    rq.req_valid    = 1'b0;
    rq.req_we       = 1'b0;
    rq.req_size     = 2'd0;
    rq.req_unsigned = 1'b0;
    rq.req_addr     = '0;
    rq.req_wdata    = '0;
    rq.rsp_ready    = 1'b0;

    #1;
    chk("r_mrd", mi.MemRead, 0);
    chk("r_mwr", mi.MemWrite, 0);
    chk("r_rv", rq.rsp_valid, 0);
    chk("r_re", rq.rsp_err, 0);
    chk("r_rd", rq.rsp_rdata, 0);
    chk("r_wd", mi.Write_data, 0);
    chk("r_ra", mi.read_address, 0);
    chk("r_wa", mi.write_address, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("r_rdy", rq.req_ready, 1);

    do_req(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0);
    do_req(0, 2'd2, 0, 32'h100, 32'h0, 0);

    mem_arr[16'h40] = 32'h11223344;
    ref_mem[16'h40] = 32'h11223344;
    do_req(1, 2'd0, 0, 32'h101, 32'hA5, 0);
    chk("sb_word", mem_arr[16'h40], 32'h1122A544);
    do_req(0, 2'd0, 0, 32'h101, 32'h0, 0);
    do_req(0, 2'd0, 1, 32'h101, 32'h0, 0);

    do_req(1, 2'd1, 0, 32'h102, 32'h8001, 0);
    chk("sh_word", mem_arr[16'h40], 32'h8001A544);
    do_req(0, 2'd1, 0, 32'h102, 32'h0, 0);
    do_req(0, 2'd1, 1, 32'h102, 32'h0, 0);

    do_req(0, 2'd2, 0, 32'h102, 32'h0, 0);
    do_req(1, 2'd1, 0, 32'h103, 32'h1234, 0);
    do_req(0, 2'd3, 0, 32'h100, 32'h0, 1);

    do_req(0, 2'd2, 0, 32'h100, 32'h0, 5);

    exp_idx = 32'h40;
    @(negedge clk);
    rq.req_valid    = 1'b1;
    rq.req_we       = 1'b1;
    rq.req_size     = 2'd0;
    rq.req_unsigned = 1'b0;
    rq.req_addr     = 32'h101;
    rq.req_wdata    = 32'h5A;
    @(posedge clk); #1;
    rq.req_valid = 1'b0;
    rd_cnt = 0; wr_cnt = 0;
    chk("x_rmwrd", mi.MemRead, 1);
    #2 reset = 1'b1;
    #1;
    chk("x_mwr", mi.MemWrite, 0);
    chk("x_mrd", mi.MemRead, 0);
    chk("x_rv", rq.rsp_valid, 0);
    chk("x_re", rq.rsp_err, 0);
    chk("x_rd", rq.rsp_rdata, 0);
    chk("x_wd", mi.Write_data, 0);
    chk("x_ra", mi.read_address, 0);
    chk("x_wa", mi.write_address, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("x_rdy", rq.req_ready, 1);
    chk("x_wcnt", wr_cnt, 0);
    chk("x_mem", mem_arr[16'h40], ref_mem[16'h40]);

    for (int n = 0; n < 200; n++) begin
      do_req(1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             32'h100 + $urandom_range(0, 63),
             $urandom,
             int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d",
             n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the CPU data-memory interface: accepts load/store requests from the execute stage over a valid/ready handshake and drives the word-addressed data memory's MemRead/MemWrite port.
- Translates byte addresses to word indices.
- Performs read-modify-write for byte and halfword stores, since the memory is word-only.
- Extracts and sign- or zero-extends sub-word loads, then returns a response to writeback.

Parameters:
- WORD_INDEX_W, 16, number of word-index bits presented to memory (65536-word memory).
- ADDR_W, 32, width of request byte address and memory address ports.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the low bits are used for sub-word stores.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  formatted load data; 0 for stores and errors.
- rsp_err  out  1  misaligned access or reserved size.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable.
- read_address  out  ADDR_W  word index, zero-padded.
- write_address  out  ADDR_W  word index, zero-padded.
- Write_data  out  32  full word to write.
- MemData_in  in  32  memory read data (combinational from read_address).

Behaviour:
- Reset is asynchronous and active-high. The unit goes to IDLE immediately.
- Reset values:
  - MemRead, MemWrite, rsp_valid, rsp_err = 0.
  - rsp_rdata, Write_data, read_address, write_address = 0.
  - req_ready = 1 once reset deasserts.
- All request fields are registered on acceptance. Memory outputs decode from the state register and captured request only (Moore), so they are glitch-free.
- Word index = {zeros, addr[WORD_INDEX_W+1:2]}. The same value drives read_address and write_address.
- Byte lanes are little-endian: lane = addr[1:0], byte 0 = bits 7:0; half lane = addr[1].
- Alignment:
  - Half requires addr[0] = 0.
  - Word requires addr[1:0] = 0.
  - Size 11 is an error.
- States:
  - IDLE: req_ready = 1. On req_valid:
    - error -> RESP with rsp_err = 1;
    - load -> LD;
    - word store -> ST;
    - sub-word store -> RMW_RD.
  - LD: MemRead = 1 for one cycle; capture formatted MemData_in into rsp_rdata -> RESP.
  - ST: MemWrite = 1 for one cycle, Write_data = req_wdata -> RESP.
  - RMW_RD: MemRead = 1; capture MemData_in into the merge register -> RMW_WR.
  - RMW_WR: MemWrite = 1; Write_data = captured word with the target lane(s) replaced by req_wdata[7:0] or [15:0] -> RESP.
  - RESP: rsp_valid = 1; rsp_rdata and rsp_err are held stable. On rsp_ready -> IDLE. req_ready = 0, so there is no same-cycle accept.
- Latency from the accept edge to rsp_valid:
  - error: 1 cycle;
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles.
- Strobes: MemRead and MemWrite are never high together. Each is high for exactly one cycle per access. An error request never touches memory.
- Load formatting:
  - Byte: lane byte extended to 32 bits.
  - Half: lane half extended.
  - Word: unchanged.
  - Extension is sign or zero per req_unsigned.
- Back-pressure: while rsp_valid && !rsp_ready, all outputs hold. req_valid is ignored outside IDLE.
- Reset mid-operation: an RMW interrupted before RMW_WR never writes. MemWrite drops asynchronously with reset.

Decomposition:
- Shared package lsu_pkg holds:
  - the size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the state enum (IDLE, LD, ST, RMW_RD, RMW_WR, RESP);
  - a misalignment check function.
- One combinational sub-module, lsu_byte_lane, performs lane extraction with sign/zero extension and lane merge for stores. It is reused in LD and RMW_WR.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, then LW 0x100 -> during ST, write_address = 0x40 with MemWrite high exactly 1 cycle; load returns rsp_rdata = 0xDEADBEEF, rsp_err = 0, 2 cycles after accept.
- Preload word 0x40 = 0x11223344; SB addr 0x101 data 0xA5 -> RMW_RD then RMW_WR writes 0x1122A544; LB 0x101 -> 0xFFFFFFA5; LBU 0x101 -> 0x000000A5.
- From 0x1122A544: SH addr 0x102 data 0x8001 -> memory 0x8001A544; LH 0x102 -> 0xFFFF8001; LHU -> 0x00008001.
- LW addr 0x102, and SH addr 0x103 -> rsp_err = 1, rsp_rdata = 0, response 1 cycle after accept, MemRead/MemWrite never asserted.
- Hold rsp_ready = 0 for 5 cycles after a load response with a second req_valid pending -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready = 0. The second request is accepted only in IDLE after the rsp_ready handshake.
- Assert reset during RMW_RD of SB 0x101 -> MemWrite never rises, memory word unchanged, all outputs 0 before the next clock edge, req_ready = 1 after release.
